// File: rtl/rtype_ctrl.sv
// rtype_ctrl: multi-cycle control sequencer for RV32I R-type and M-extension multiplies.
// Define RTYPE_CTRL_MU_WDT_EN to fault the instruction when the MU stalls for MU_TIMEOUT cycles.
module rtype_ctrl #(
    parameter int pcmux_N     = 2,
    parameter int ifuresctl_N = 2,
    parameter int MU_TIMEOUT  = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    input  logic [6:0]                     opcode,
    input  logic [2:0]                     func3,
    input  logic [1:0]                     func7b50,
    input  logic                           exdone,
    output logic [$clog2(pcmux_N)-1:0]     pcmuxctl,
    output logic                           pcnextctl,
    output logic                           instrre,
    output logic                           regre,
    output logic                           regwe,
    output logic                           mulen,
    output logic [3:0]                     aluctl,
    output logic [1:0]                     mulctl,
    output logic [$clog2(ifuresctl_N)-1:0] ifuresctl,
    output logic                           retire,
    output logic                           illegal,
    output logic                           busy
);
    localparam int IW = $clog2(ifuresctl_N);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WAIT_MU, WB, HALT} state_t;

    typedef struct packed {
        logic          instrre;
        logic          regre;
        logic          regwe;
        logic          pcnextctl;
        logic          mulen;
        logic          retire;
        logic          illegal;
        logic          busy;
        logic [3:0]    aluctl;
        logic [1:0]    mulctl;
        logic [IW-1:0] ifuresctl;
    } out_t;

    state_t     state_q, state_d;
    out_t       out_q, out_d;
    logic [3:0] aluop_q, aluop_d, dec_alu;
    logic [1:0] mulop_q, mulop_d;
    logic       is_mul_q, is_mul_d, dec_ill, mu_timeout, in_ex;

    always_comb begin
        dec_ill = opcode != 7'b0110011 || func7b50 == 2'b11
               || (func7b50 == 2'b01 && func3[2])
               || (func7b50 == 2'b10 && func3 != 3'b000 && func3 != 3'b101);
        dec_alu = 4'd0;
        case (func3)
            3'b000: dec_alu = func7b50[1] ? 4'd1 : 4'd0;
            3'b001: dec_alu = 4'd2;
            3'b010: dec_alu = 4'd3;
            3'b011: dec_alu = 4'd4;
            3'b100: dec_alu = 4'd5;
            3'b101: dec_alu = func7b50[1] ? 4'd7 : 4'd6;
            3'b110: dec_alu = 4'd8;
            3'b111: dec_alu = 4'd9;
        endcase
        aluop_d  = state_q == DECODE ? (func7b50[0] ? 4'd0 : dec_alu) : aluop_q;
        mulop_d  = state_q == DECODE ? (func7b50[0] ? func3[1:0] : 2'd0) : mulop_q;
        is_mul_d = state_q == DECODE ? func7b50[0] : is_mul_q;
    end

`ifdef RTYPE_CTRL_MU_WDT_EN
    localparam int CW = $clog2(MU_TIMEOUT + 1);
    logic [CW-1:0] wdt_q, wdt_d;

    // Counter is zero on the first WAIT_MU cycle, so the limit is MU_TIMEOUT-1.
    always_comb wdt_d = state_q == WAIT_MU ? wdt_q + CW'(1) : '0;
    assign mu_timeout = wdt_q == CW'(MU_TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) wdt_q <= '0;
        else        wdt_q <= wdt_d;
    end
`else
    logic unused_mu_timeout;
    assign unused_mu_timeout = ^MU_TIMEOUT;
    assign mu_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = run ? FETCH : IDLE;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = dec_ill ? HALT : EXEC;
            EXEC:    state_d = is_mul_q ? WAIT_MU : exdone ? WB : EXEC;
            WAIT_MU: state_d = exdone ? WB : mu_timeout ? HALT : WAIT_MU;
            WB:      state_d = run ? FETCH : IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with the state register.
    always_comb begin
        in_ex           = state_d == EXEC || state_d == WAIT_MU || state_d == WB;
        out_d           = '0;
        out_d.instrre   = state_d == FETCH;
        out_d.regre     = state_d == DECODE;
        out_d.regwe     = state_d == WB;
        out_d.pcnextctl = state_d == WB;
        out_d.retire    = state_d == WB;
        out_d.mulen     = state_d == EXEC && is_mul_d;
        out_d.illegal   = out_q.illegal || state_d == HALT;
        out_d.busy      = state_d != IDLE && state_d != HALT;
        out_d.aluctl    = in_ex ? aluop_d : 4'd0;
        out_d.mulctl    = in_ex ? mulop_d : 2'd0;
        out_d.ifuresctl = IW'(in_ex && is_mul_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out_q    <= '0;
            aluop_q  <= '0;
            mulop_q  <= '0;
            is_mul_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            aluop_q  <= aluop_d;
            mulop_q  <= mulop_d;
            is_mul_q <= is_mul_d;
        end
    end

    assign pcmuxctl = '0;
    assign {instrre, regre, regwe, pcnextctl, mulen, retire, illegal, busy,
            aluctl, mulctl, ifuresctl} = out_q;
endmodule

// File: tb/tb_rtype_ctrl.sv
// tb_rtype_ctrl: directed plus randomized checks of rtype_ctrl against a phase-sequence reference model.
module tb_rtype_ctrl;
    logic       clk, rst_n, run, exdone;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [1:0] func7b50;
    logic [0:0] pcmuxctl, ifuresctl;
    logic       pcnextctl, instrre, regre, regwe, mulen, retire, illegal, busy;
    logic [3:0] aluctl;
    logic [1:0] mulctl;

    typedef enum {P_IDLE, P_F, P_D, P_E, P_W, P_WB, P_HALT} phase_t;

    typedef struct packed {
        logic       pcmux;
        logic       instrre;
        logic       regre;
        logic       regwe;
        logic       pcnext;
        logic       mulen;
        logic       retire;
        logic       illegal;
        logic       busy;
        logic [3:0] aluctl;
        logic [1:0] mulctl;
        logic       ifures;
    } vec_t;

    int         checks = 0, failures = 0, cyc = 0;
    int         alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    logic       cur_legal, cur_ismul;
    logic [3:0] cur_alu;
    logic [1:0] cur_mul;
    logic [2:0] rf3;
    logic [1:0] rf7;

    rtype_ctrl #(.pcmux_N(2), .ifuresctl_N(2), .MU_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .func3(func3),
        .func7b50(func7b50), .exdone(exdone), .pcmuxctl(pcmuxctl),
        .pcnextctl(pcnextctl), .instrre(instrre), .regre(regre), .regwe(regwe),
        .mulen(mulen), .aluctl(aluctl), .mulctl(mulctl), .ifuresctl(ifuresctl),
        .retire(retire), .illegal(illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [1:0] f7);
        opcode    = opc;
        func3     = f3;
        func7b50  = f7;
        cur_legal = opc == 7'h33 && (f7 == 2'd0 || (f7 == 2'd1 && f3 < 3'd4)
                    || (f7 == 2'd2 && (f3 == 3'd0 || f3 == 3'd5)));
        cur_ismul = f7 == 2'd1;
        cur_mul   = f3[1:0];
        cur_alu   = 4'(alu_tab[f3] + (f7 == 2'd2 ? 1 : 0));
    endtask

    function automatic vec_t expv(input phase_t p);
        vec_t v;
        v         = '0;
        v.busy    = p != P_IDLE && p != P_HALT;
        v.instrre = p == P_F;
        v.regre   = p == P_D;
        v.regwe   = p == P_WB;
        v.pcnext  = p == P_WB;
        v.retire  = p == P_WB;
        v.mulen   = p == P_E && cur_ismul;
        v.illegal = p == P_HALT;
        if (p == P_E || p == P_W || p == P_WB) begin
            v.aluctl = cur_ismul ? 4'd0 : cur_alu;
            v.mulctl = cur_ismul ? cur_mul : 2'd0;
            v.ifures = cur_ismul;
        end
        return v;
    endfunction

    task automatic check(input string tag, input phase_t p);
        vec_t e, o;
        e = expv(p);
        o = {pcmuxctl, instrre, regre, regwe, pcnextctl, mulen, retire, illegal, busy,
             aluctl, mulctl, ifuresctl};
        // The op field of the unit not in use is unconstrained.
        if (p == P_E || p == P_W || p == P_WB) begin
            if (cur_ismul) o.aluctl = e.aluctl;
            else           o.mulctl = e.mulctl;
        end
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s cyc=%0d phase=%s observed=%h expected=%h", tag, cyc, p.name(), o, e);
        end
    endtask

    task automatic do_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [1:0] f7, input int lat, input logic run_after,
                            input int abort_at);
        int     n;
        phase_t p;
        load_instr(opc, f3, f7);
        run = 1'b1;
        n = !cur_legal ? 2 : cur_ismul ? 4 + lat : 4;
        for (int c = 1; c <= n; c++) begin
            step();
            p = c == 1 ? P_F : c == 2 ? P_D : c == 3 ? P_E : c == n ? P_WB : P_W;
            check(tag, p);
            if (c == abort_at) begin
                rst_n  = 1'b0;
                run    = 1'b0;
                exdone = 1'b0;
                step();
                check({tag, "_rst"}, P_IDLE);
                rst_n  = 1'b1;
                exdone = 1'b1;
                repeat (3) begin
                    step();
                    check({tag, "_after_rst"}, P_IDLE);
                end
                exdone = 1'b0;
                return;
            end
            exdone = (!cur_ismul && c == 3) || (cur_ismul && c == 3 + lat) ? 1'b1
                   : (cur_ismul && c > 3) ? 1'b0 : 1'($urandom_range(0, 1));
            run = c == n ? run_after : 1'($urandom_range(0, 1));
        end
        if (!cur_legal) begin
            run = 1'b1;
            repeat (4) begin
                step();
                check({tag, "_halt"}, P_HALT);
            end
            rst_n = 1'b0;
            step();
            check({tag, "_rst"}, P_IDLE);
            rst_n = 1'b1;
            run   = 1'b0;
        end else if (!run_after) begin
            step();
            check({tag, "_idle"}, P_IDLE);
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; exdone = 1'b0;
        opcode = '0; func3 = '0; func7b50 = '0;
        cur_legal = 1'b0; cur_ismul = 1'b0; cur_alu = '0; cur_mul = '0;
        repeat (2) step();
        check("reset", P_IDLE);
        rst_n = 1'b1;
        step();
        check("idle_run0", P_IDLE);

        do_instr("add",   7'h33, 3'b000, 2'b00, 0, 1'b1, 0);
        do_instr("sub",   7'h33, 3'b000, 2'b10, 0, 1'b1, 0);
        do_instr("sra",   7'h33, 3'b101, 2'b10, 0, 1'b1, 0);
        do_instr("xor",   7'h33, 3'b100, 2'b00, 0, 1'b1, 0);
        do_instr("or",    7'h33, 3'b110, 2'b00, 0, 1'b1, 0);
        do_instr("and",   7'h33, 3'b111, 2'b00, 0, 1'b0, 0);
        do_instr("mulhu", 7'h33, 3'b011, 2'b01, 5, 1'b0, 0);
        do_instr("mul1",  7'h33, 3'b000, 2'b01, 1, 1'b1, 0);
        do_instr("div",   7'h33, 3'b100, 2'b01, 0, 1'b1, 0);
        do_instr("addi",  7'h13, 3'b000, 2'b00, 0, 1'b1, 0);
        do_instr("f7_11", 7'h33, 3'b000, 2'b11, 0, 1'b1, 0);
        do_instr("sub_f3",7'h33, 3'b001, 2'b10, 0, 1'b1, 0);
        do_instr("rst_wait", 7'h33, 3'b011, 2'b01, 10, 1'b1, 6);

        for (int i = 0; i < 30; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            rf7 = 2'($urandom_range(0, 3));
            do_instr("rand", 7'h33, rf3, rf7, int'($urandom_range(1, 6)),
                     1'($urandom_range(0, 1)), 0);
        end

        load_instr(7'h33, 3'b011, 2'b01);
        run = 1'b1;
        exdone = 1'b0;
        step(); check("hang_f", P_F);
        step(); check("hang_d", P_D);
        step(); check("hang_e", P_E);
`ifdef RTYPE_CTRL_MU_WDT_EN
        repeat (8) begin
            step();
            check("wdt_wait", P_W);
        end
        step();
        check("wdt_halt", P_HALT);
`else
        repeat (100) begin
            step();
            check("mu_hold", P_W);
        end
        exdone = 1'b1;
        step();
        check("mu_hold_wb", P_WB);
        run = 1'b0;
        exdone = 1'b0;
        step();
        check("mu_hold_idle", P_IDLE);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
